// File: rtl/stepped_loop_engine.sv
// Counted-loop micro-sequencer applying one compound operator per iteration to an accumulator.
// Latency N+1 cycles (1 for zero iterations); result held in DONE until i_ready, start ignored while busy.
module stepped_loop_engine #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [3:0]           i_op,
    input  logic                 i_step_mode,
    input  logic [WIDTH-1:0]     i_init,
    input  logic [WIDTH-1:0]     i_operand,
    input  logic [IDX_WIDTH-1:0] i_begin,
    input  logic [IDX_WIDTH-1:0] i_limit,
    input  logic [IDX_WIDTH-1:0] i_step,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_result,
    output logic [IDX_WIDTH-1:0] o_count,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LP_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;

    logic [3:0]             r_op;
    logic                   r_step_mode;
    logic [WIDTH-1:0]       r_operand;
    logic [IDX_WIDTH-1:0]   r_limit;
    logic [IDX_WIDTH-1:0]   r_step;
    logic [WIDTH-1:0]       r_acc;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [IDX_WIDTH-1:0]   r_count;
    logic                   r_err;

    logic [WIDTH-1:0]       w_acc_op;
    logic                   w_div_zero;
    logic                   w_shamt_big;
    logic [IDX_WIDTH:0]     w_idx_sum;
    logic [2*IDX_WIDTH-1:0] w_idx_prod;
    logic [IDX_WIDTH-1:0]   w_idx_next;
    logic                   w_idx_ovf;
    logic                   w_no_prog;
    logic [IDX_WIDTH-1:0]   w_cnt_next;
    logic                   w_cnt_sat;
    logic                   w_iter_err;
    logic                   w_iter_last;
    logic                   w_op_rsvd;
    logic                   w_empty_loop;

    assign w_op_rsvd    = (i_op >= 4'd13);
    assign w_empty_loop = (i_begin >= i_limit);

    // Shift amounts are the full operand, so compare in a width that holds both WIDTH and the operand.
    assign w_shamt_big = ({32'b0, r_operand} >= {{WIDTH{1'b0}}, 32'(WIDTH)});

    always_comb begin
        w_acc_op   = r_acc;
        w_div_zero = 1'b0;
        case (r_op)
            4'd0:  w_acc_op = r_operand;
            4'd1:  w_acc_op = r_acc + r_operand;
            4'd2:  w_acc_op = r_acc - r_operand;
            4'd3:  w_acc_op = r_acc * r_operand;
            4'd4: begin
                if (r_operand == '0) w_div_zero = 1'b1;
                else                 w_acc_op   = r_acc / r_operand;
            end
            4'd5: begin
                if (r_operand == '0) w_div_zero = 1'b1;
                else                 w_acc_op   = r_acc % r_operand;
            end
            4'd6:  w_acc_op = r_acc & r_operand;
            4'd7:  w_acc_op = r_acc | r_operand;
            4'd8:  w_acc_op = r_acc ^ r_operand;
            4'd9, 4'd11: w_acc_op = w_shamt_big ? '0 : (r_acc << r_operand);
            4'd10: w_acc_op = w_shamt_big ? '0 : (r_acc >> r_operand);
            4'd12: w_acc_op = w_shamt_big ? {WIDTH{r_acc[WIDTH-1]}}
                                          : $unsigned($signed(r_acc) >>> r_operand);
            default: w_acc_op = r_acc;
        endcase
    end

    // Index advance with carry/overflow detection in a widened result.
    assign w_idx_sum  = {1'b0, r_idx} + {1'b0, r_step};
    assign w_idx_prod = {{IDX_WIDTH{1'b0}}, r_idx} * {{IDX_WIDTH{1'b0}}, r_step};
    assign w_idx_next = r_step_mode ? w_idx_prod[IDX_WIDTH-1:0] : w_idx_sum[IDX_WIDTH-1:0];
    assign w_idx_ovf  = r_step_mode ? (|w_idx_prod[2*IDX_WIDTH-1:IDX_WIDTH]) : w_idx_sum[IDX_WIDTH];
    assign w_no_prog  = r_step_mode ? ((r_idx == '0) || (r_step[IDX_WIDTH-1:1] == '0))
                                    : (r_step == '0);

    assign w_cnt_next  = (&r_count) ? r_count : (r_count + LP_ONE);
    assign w_cnt_sat   = &w_cnt_next;
    assign w_iter_err  = w_div_zero | w_idx_ovf | w_no_prog | w_cnt_sat;
    assign w_iter_last = w_iter_err | (w_idx_next >= r_limit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = (w_empty_loop || w_op_rsvd) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_iter_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= '0;
            r_step_mode <= 1'b0;
            r_operand   <= '0;
            r_limit     <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op        <= i_op;
                        r_step_mode <= i_step_mode;
                        r_operand   <= i_operand;
                        r_limit     <= i_limit;
                        r_step      <= i_step;
                        r_acc       <= i_init;
                        r_idx       <= i_begin;
                        r_count     <= '0;
                        // An empty loop finishes cleanly even if the opcode is reserved.
                        r_err       <= !w_empty_loop && w_op_rsvd;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_op;
                    r_idx   <= w_idx_next;
                    r_count <= w_cnt_next;
                    r_err   <= w_iter_err;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state == ST_RUN);
    assign o_valid  = (r_state == ST_DONE);
    assign o_result = o_valid ? r_acc   : '0;
    assign o_count  = o_valid ? r_count : '0;
    assign o_err    = o_valid & r_err;

endmodule
